// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the state/owner types used by the memory arbiter.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int ALEN     = 32;
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    typedef enum logic [1:0] {NONE, FETCH, DATA} arb_owner_t;

endpackage

// File: rtl/arb_priority_pick.sv
// Fixed-priority pick between fetch and data with a saturating anti-starvation streak.
module arb_priority_pick
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic                if_abort,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_if,
    output logic                grant_d,
    output logic [STREAK_W-1:0] streak_next
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic fetch_ok;
    logic fetch_due;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        fetch_ok    = if_req && !if_abort;
        fetch_due   = fetch_ok && (streak == LIMIT);
        grant_d     = d_req && !fetch_due;
        grant_if    = fetch_ok && !grant_d;
        streak_next = streak;
        if (grant_if) begin
            streak_next = '0;
        end else if (grant_d) begin
            if (!if_req) begin
                streak_next = '0;
            end else if (streak < LIMIT) begin
                streak_next = streak + STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data ports, one transaction in flight,
// data-first priority with a bounded wait for fetch and redirect (abort) support.
module mem_arbiter #(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int ALEN         = riscv_pkg::ALEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [ALEN-1:0] if_addr,
    input  logic            if_abort,
    output logic [31:0]     if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam int SW = riscv_pkg::STREAK_W;

    riscv_pkg::arb_state_t state, state_n;
    riscv_pkg::arb_owner_t owner, owner_n;
    logic [SW-1:0]         streak, streak_n, pick_streak;
    logic                  abort_pend, abort_n;
    logic                  req_n, load;
    logic                  grant_if, grant_d;
    logic                  fetch_owner;

    arb_priority_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .if_abort    (if_abort),
        .streak      (streak),
        .grant_if    (grant_if),
        .grant_d     (grant_d),
        .streak_next (pick_streak)
    );

    assign fetch_owner = (owner == riscv_pkg::FETCH);
    assign if_rdata    = mem_rdata[31:0];
    assign d_rdata     = mem_rdata;
    assign busy        = (state != riscv_pkg::IDLE);

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        streak_n = streak;
        abort_n  = abort_pend;
        req_n    = mem_req;
        load     = 1'b0;
        if_ready = 1'b0;
        d_ready  = 1'b0;
        case (state)
            riscv_pkg::IDLE: begin
                if (grant_if || grant_d) begin
                    state_n  = riscv_pkg::ISSUE;
                    owner_n  = grant_d ? riscv_pkg::DATA : riscv_pkg::FETCH;
                    streak_n = pick_streak;
                    abort_n  = 1'b0;
                    req_n    = 1'b1;
                    load     = 1'b1;
                end
            end
            riscv_pkg::ISSUE: begin
                // A grant wins over a same-cycle abort: the response must still be drained.
                if (mem_gnt) begin
                    state_n = riscv_pkg::WAIT;
                    req_n   = 1'b0;
                    if (fetch_owner && if_abort) abort_n = 1'b1;
                end else if (fetch_owner && if_abort) begin
                    state_n = riscv_pkg::IDLE;
                    owner_n = riscv_pkg::NONE;
                    req_n   = 1'b0;
                end
            end
            riscv_pkg::WAIT: begin
                if (fetch_owner && if_abort) abort_n = 1'b1;
                if (mem_rvalid) begin
                    if_ready = fetch_owner && !abort_pend && !if_abort;
                    d_ready  = (owner == riscv_pkg::DATA);
                    state_n  = riscv_pkg::IDLE;
                    owner_n  = riscv_pkg::NONE;
                    abort_n  = 1'b0;
                end
            end
            default: state_n = riscv_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of order.
        if (rst) begin
            state      <= riscv_pkg::IDLE;
            owner      <= riscv_pkg::NONE;
            streak     <= '0;
            abort_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            streak     <= streak_n;
            abort_pend <= abort_n;
            mem_req    <= req_n;
            if (load) begin
                mem_we    <= grant_d && d_we;
                mem_addr  <= grant_d ? d_addr : if_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                mem_be    <= grant_d ? d_be : 4'b1111;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port backing memory between the pipeline's instruction-fetch port and data port. Arbitration is fixed-priority toward data, with an anti-starvation limit for fetch. Each requester sees a req/ready handshake, and the CPU holds its stage while ready is low. The block sits between the CPU's imem/dmem interfaces and the unified BRAM/bus memory, and allows one outstanding memory transaction at a time.

Parameters:
XLEN, riscv_pkg::XLEN (32), data width
ALEN, riscv_pkg::ALEN (32), address width
STARVE_LIMIT, 4, max consecutive data grants while fetch is waiting; range 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ALEN  fetch address
if_abort  in  1  redirect: discard the current fetch
if_rdata  out  32  fetched instruction; valid when if_ready=1
if_ready  out  1  one-cycle completion pulse
d_req  in  1  data request; held until d_ready
d_we  in  1  1=store
d_addr  in  ALEN  data address
d_wdata  in  XLEN  store data
d_be  in  4  byte enables
d_rdata  out  XLEN  load data; valid when d_ready=1
d_ready  out  1  one-cycle completion pulse
mem_req  out  1  memory request; held until mem_gnt
mem_we  out  1  write strobe
mem_addr  out  ALEN  address
mem_wdata  out  XLEN  write data
mem_be  out  4  byte enables (4'b1111 for fetch)
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response for the accepted request; one per request, loads and stores alike
mem_rdata  in  XLEN  read data
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; if_ready=0, d_ready=0; streak=0; owner=NONE; abort_pend=0; busy=0.
- States:
  - IDLE: on any request, pick the winner, register its payload into the mem_* regs, go to ISSUE. No request: stay in IDLE.
  - ISSUE: mem_req=1. On mem_gnt, go to WAIT.
  - WAIT: on mem_rvalid, pulse the owner's ready for that same cycle, then go to IDLE.
- Arbitration (IDLE only):
  - Only d_req: grant data. Only if_req: grant fetch.
  - Both requesting: grant data unless streak==STARVE_LIMIT, in which case grant fetch.
  - streak increments on a data grant while if_req=1. It clears on any fetch grant, or on a data grant while if_req=0. It saturates at STARVE_LIMIT.
- Read data: if_rdata=mem_rdata[31:0] and d_rdata=mem_rdata, passed through combinationally. Both are undefined when the matching ready is 0.
- Latency: minimum 2 cycles, request sampled to ready (IDLE→ISSUE with gnt→WAIT with rvalid). The next grant comes no earlier than the cycle after ready, so there is one IDLE bubble.
- mem_* outputs are registered and stay stable from ISSUE entry until mem_gnt. A requester that drops req early does not cancel the transaction; its ready still pulses.
- if_abort:
  - In IDLE: blocks fetch arbitration that cycle.
  - In ISSUE with fetch owner and no gnt in the same cycle: drop mem_req, return to IDLE, no if_ready.
  - With gnt in the same cycle, or in WAIT: set abort_pend. The response is consumed with if_ready suppressed, then the block returns to IDLE.
- mem_rvalid seen in IDLE or ISSUE is ignored; no state change.
- Reset mid-transaction: the block returns to IDLE at once. The memory must itself be reset in the same cycle; no orphan response is tracked.
- mem_gnt and mem_rvalid in the same ISSUE cycle: the gnt is taken and the rvalid is ignored. The memory must never do this; the testbench asserts it.

Decomposition:
- Shared package riscv_pkg gains arb_state_t (IDLE, ISSUE, WAIT) and arb_owner_t (NONE, FETCH, DATA). XLEN/ALEN already live there.
- One sub-module, arb_priority_pick: combinational; takes if_req, d_req, if_abort and streak; returns grant_if, grant_d and next streak. It is unit-testable on its own.
- Target size: about 200 lines.

Test Plan:
- Single fetch, addr=0x100, memory with 1-cycle response 0x00000013 → mem_req at cycle 1, if_ready at cycle 2 with if_rdata=0x00000013; busy low at cycle 3.
- Simultaneous if_req and d_req (load 0x2000, data 0xDEADBEEF) → data served first (d_ready, d_rdata=0xDEADBEEF), then fetch granted on the next IDLE.
- d_req held continuously with if_req high, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, then the streak restarts at 0.
- Store d_we=1, d_be=4'b0100, addr=0x3001, mem_gnt delayed 3 cycles → mem_addr/mem_wdata/mem_be held stable for all 4 ISSUE cycles; d_ready only on rvalid.
- if_abort in ISSUE before gnt → mem_req deasserts the next cycle and no if_ready. if_abort in WAIT → response consumed, if_ready stays 0, state returns to IDLE.
- rst asserted in WAIT → the next cycle shows every output at its reset value. A stray mem_rvalid afterward produces no ready pulse.
